// File: rtl/ssb_demod_pipe.sv
// ssb_demod_pipe: three-stage I/Q combiner for the receive chain.
// Stage 1 registers the sample and its per-sample controls, stage 2 forms the
// USB/LSB/AM/mute result at full precision, stage 3 applies the gain shift,
// the fixed halving and the saturation to the output width.
`timescale 1ns/1ps

module ssb_demod_pipe #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 12,
    parameter int GAIN_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    input  logic [1:0]        mode,
    input  logic [GAIN_W-1:0] gain_shift,
    input  logic              clear_sat,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              sat_pulse,
    output logic              sat_flag
);

    // Combiner result is exact in one extra bit; the scaled value must hold
    // the largest left shift without losing the sign.
    localparam int R_W = DATA_W + 1;
    localparam int V_W = DATA_W + (1 << GAIN_W);

    localparam logic signed [V_W-1:0] SAT_MAX = {{(V_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [V_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [1:0] MODE_USB = 2'b00;
    localparam logic [1:0] MODE_LSB = 2'b01;
    localparam logic [1:0] MODE_AM  = 2'b10;

    function automatic logic signed [R_W-1:0] sext_fn(input logic signed [DATA_W-1:0] x);
        return {x[DATA_W-1], x};
    endfunction

    // |x| in R_W bits, so the most negative input maps to +2^(DATA_W-1) exactly.
    function automatic logic signed [R_W-1:0] abs_fn(input logic signed [DATA_W-1:0] x);
        logic signed [R_W-1:0] e;
        e = sext_fn(x);
        return e[R_W-1] ? -e : e;
    endfunction

    function automatic logic signed [R_W-1:0] combine_fn(
        input logic signed [DATA_W-1:0] i,
        input logic signed [DATA_W-1:0] q,
        input logic [1:0]               m
    );
        logic signed [R_W-1:0] a;
        logic signed [R_W-1:0] b;
        logic signed [R_W-1:0] mx;
        logic signed [R_W-1:0] mn;
        logic signed [R_W-1:0] r;
        a = abs_fn(i);
        b = abs_fn(q);
        if (a > b) begin
            mx = a;
            mn = b;
        end else begin
            mx = b;
            mn = a;
        end
        case (m)
            MODE_USB: r = sext_fn(i) + sext_fn(q);
            MODE_LSB: r = sext_fn(i) - sext_fn(q);
            // alpha-max-beta-min envelope; both terms non-negative, shift floors
            MODE_AM:  r = mx + (mn >>> 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Gain shift followed by the fixed halving; arithmetic shift floors toward -inf.
    function automatic logic signed [V_W-1:0] scale_fn(
        input logic signed [R_W-1:0] r,
        input logic [GAIN_W-1:0]     g
    );
        logic signed [V_W-1:0] v;
        v = {{(V_W-R_W){r[R_W-1]}}, r};
        v = v <<< g;
        return v >>> 1;
    endfunction

    // Returns {clipped, saturated value}.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [V_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic                     vld_p0;
    logic signed [DATA_W-1:0] i_p0;
    logic signed [DATA_W-1:0] q_p0;
    logic [1:0]               mode_p0;
    logic [GAIN_W-1:0]        gain_p0;

    logic                     vld_p1;
    logic signed [R_W-1:0]    r_p1;
    logic [GAIN_W-1:0]        gain_p1;

    logic signed [R_W-1:0]    r_c;
    logic [OUT_W:0]           sat_c;

    // Stage 1: capture the sample with its mode and gain; idle cycles leave data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            i_p0    <= '0;
            q_p0    <= '0;
            mode_p0 <= '0;
            gain_p0 <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                i_p0    <= in_i;
                q_p0    <= in_q;
                mode_p0 <= mode;
                gain_p0 <= gain_shift;
            end
        end
    end

    // Stage 2 combinational: sideband / envelope / mute combiner
    always_comb begin
        r_c = combine_fn(i_p0, q_p0, mode_p0);
    end

    // Stage 2: register the full-precision result and carry the gain along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            r_p1    <= '0;
            gain_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                r_p1    <= r_c;
                gain_p1 <= gain_p0;
            end
        end
    end

    // Stage 3 combinational: scale and saturate to the output width
    always_comb begin
        sat_c = sat_fn(scale_fn(r_p1, gain_p1));
    end

    // Stage 3: output register; data holds through bubbles, sticky flag favours set over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_pulse <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            sat_pulse <= vld_p1 & sat_c[OUT_W];
            if (vld_p1)
                out_data <= sat_c[OUT_W-1:0];
            if (vld_p1 && sat_c[OUT_W])
                sat_flag <= 1'b1;
            else if (clear_sat)
                sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssb_demod_pipe.sv
// Bench for ssb_demod_pipe: directed scenarios plus a randomized run against
// an integer reference model of the demodulator.
`timescale 1ns/1ps

module tb_ssb_demod_pipe;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [11:0] in_i = '0;
    logic signed [11:0] in_q = '0;
    logic [1:0]        mode = '0;
    logic [2:0]        gain_shift = '0;
    logic              clear_sat = 1'b0;
    logic              out_valid;
    logic signed [11:0] out_data;
    logic              sat_pulse;
    logic              sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit v;
        int d;
        bit p;
    } exp_t;

    ssb_demod_pipe #(.DATA_W(12), .OUT_W(12), .GAIN_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .mode      (mode),
        .gain_shift(gain_shift),
        .clear_sat (clear_sat),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat_pulse (sat_pulse),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: mode arithmetic on integers, multiply by 2^g, floor-halve, clamp.
    function automatic int model(input int i, input int q, input int m, input int g, output bit clip);
        int r, a, b, x, v;
        a = (i < 0) ? -i : i;
        b = (q < 0) ? -q : q;
        case (m)
            0: r = i + q;
            1: r = i - q;
            2: r = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
            default: r = 0;
        endcase
        x = r * (1 << g);
        v = (x >= 0) ? x / 2 : -((-x + 1) / 2);
        clip = (v > 2047) || (v < -2048);
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample; on return the outputs show its result. clr drives
    // clear_sat on the edge that registers the result.
    task automatic run_one(input int i, input int q, input int m, input int g, input bit clr);
        in_valid = 1'b1; in_i = 12'(i); in_q = 12'(q); mode = 2'(m); gain_shift = 3'(g);
        tick();
        in_valid = 1'b0;
        tick();
        clear_sat = clr;
        tick();
        clear_sat = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 12'(0)) $display("FAIL rst_data: got %0d want 0", out_data); else n_pass++;
        n_checks++; if (sat_pulse !== 1'b0) $display("FAIL rst_pulse: got %b want 0", sat_pulse); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL rst_flag: got %b want 0", sat_flag); else n_pass++;
        rst = 1'b0;
        // clipping stream so the sticky flag is set before the mid-stream reset
        in_valid = 1'b1; in_i = 12'(2047); in_q = 12'(2047); mode = 2'd0; gain_shift = 3'd1;
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL pre_rst_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL pre_rst_flag: got %b want 1", sat_flag); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 12'(0)) $display("FAIL async_rst_data: got %0d want 0", out_data); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL async_rst_flag: got %b want 0", sat_flag); else n_pass++;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flushed_valid[%0d]: got %b want 0", k, out_valid); else n_pass++;
        end
        // latency: USB 1000/500 -> 750 exactly three edges later
        in_valid = 1'b1; in_i = 12'(1000); in_q = 12'(500); mode = 2'd0; gain_shift = 3'd0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_early1: got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_early2: got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 12'(750)) $display("FAIL lat_data: got %0d want 750", out_data); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_after: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 12'(750)) $display("FAIL lat_hold: got %0d want 750", out_data); else n_pass++;
    endtask

    task automatic test_sideband();
        run_one(1000, 500, 1, 0, 1'b0);
        n_checks++; if (out_data !== 12'(250)) $display("FAIL lsb_basic: got %0d want 250", out_data); else n_pass++;
        run_one(-1, 0, 0, 0, 1'b0);
        n_checks++; if (out_data !== 12'(-1)) $display("FAIL usb_floor: got %0d want -1", out_data); else n_pass++;
        run_one(-2048, -2048, 0, 0, 1'b0);
        n_checks++; if (out_data !== 12'(-2048)) $display("FAIL usb_negfull: got %0d want -2048", out_data); else n_pass++;
        n_checks++; if (sat_pulse !== 1'b0) $display("FAIL usb_negfull_pulse: got %b want 0", sat_pulse); else n_pass++;
    endtask

    task automatic test_saturation();
        run_one(2047, 2047, 0, 0, 1'b0);
        n_checks++; if (out_data !== 12'(2047)) $display("FAIL sat_g0_data: got %0d want 2047", out_data); else n_pass++;
        n_checks++; if (sat_pulse !== 1'b0) $display("FAIL sat_g0_pulse: got %b want 0", sat_pulse); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_g0_flag: got %b want 0", sat_flag); else n_pass++;
        run_one(2047, 2047, 0, 1, 1'b0);
        n_checks++; if (out_data !== 12'(2047)) $display("FAIL sat_g1_data: got %0d want 2047", out_data); else n_pass++;
        n_checks++; if (sat_pulse !== 1'b1) $display("FAIL sat_g1_pulse: got %b want 1", sat_pulse); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_g1_flag: got %b want 1", sat_flag); else n_pass++;
        tick();
        n_checks++; if (sat_pulse !== 1'b0) $display("FAIL sat_pulse_idle: got %b want 0", sat_pulse); else n_pass++;
        run_one(10, 10, 0, 0, 1'b0);
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_sticky: got %b want 1", sat_flag); else n_pass++;
        run_one(-2048, 2047, 1, 1, 1'b0);
        n_checks++; if (out_data !== 12'(-2048)) $display("FAIL sat_lsb_data: got %0d want -2048", out_data); else n_pass++;
        n_checks++; if (sat_pulse !== 1'b1) $display("FAIL sat_lsb_pulse: got %b want 1", sat_pulse); else n_pass++;
        run_one(2047, 2047, 0, 1, 1'b1);
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL clear_with_clip: got %b want 1", sat_flag); else n_pass++;
        clear_sat = 1'b1;
        tick();
        clear_sat = 1'b0;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL clear_alone: got %b want 0", sat_flag); else n_pass++;
    endtask

    task automatic test_am_mute();
        run_one(-300, 400, 2, 0, 1'b0);
        n_checks++; if (out_data !== 12'(275)) $display("FAIL am_basic: got %0d want 275", out_data); else n_pass++;
        run_one(-2048, 0, 2, 0, 1'b0);
        n_checks++; if (out_data !== 12'(1024)) $display("FAIL am_negfull: got %0d want 1024", out_data); else n_pass++;
        run_one(0, 0, 2, 0, 1'b0);
        n_checks++; if (out_data !== 12'(0)) $display("FAIL am_zero: got %0d want 0", out_data); else n_pass++;
        run_one(1000, 500, 0, 0, 1'b0);
        run_one(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 3, int'($urandom_range(0, 7)), 1'b0);
        n_checks++; if (out_data !== 12'(0)) $display("FAIL mute_data: got %0d want 0", out_data); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mute_valid: got %b want 1", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int exp_bb[4] = '{750, 250, 625, 0};
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4); in_i = 12'(1000); in_q = 12'(500); mode = 2'(k); gain_shift = 3'd0;
            tick();
            if (k >= 2) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k-2, out_valid); else n_pass++;
                n_checks++; if (out_data !== 12'(exp_bb[k-2])) $display("FAIL b2b_data[%0d]: got %0d want %0d", k-2, out_data, exp_bb[k-2]); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_bubbles();
        bit pat[5]  = '{1, 0, 1, 1, 0};
        int ival[5] = '{100, -777, 200, 300, 1500};
        int expd[5] = '{50, 50, 100, 150, 150};
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                in_valid = pat[k]; in_i = 12'(ival[k]); in_q = 12'(0);
                mode = pat[k] ? 2'd0 : 2'd2; gain_shift = pat[k] ? 3'd0 : 3'd5;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 2) begin
                n_checks++; if (out_valid !== pat[k-2]) $display("FAIL bub_valid[%0d]: got %b want %b", k-2, out_valid, pat[k-2]); else n_pass++;
                n_checks++; if (out_data !== 12'(expd[k-2])) $display("FAIL bub_data[%0d]: got %0d want %0d", k-2, out_data, expd[k-2]); else n_pass++;
            end
        end
    endtask

    task automatic test_random(input int n);
        exp_t q[$];
        exp_t e, o;
        int last_d, i, qq, m, g;
        bit flag, clr, clip, v;
        run_one(5, 5, 3, 0, 1'b0);
        clear_sat = 1'b1;
        tick();
        clear_sat = 1'b0;
        last_d = 0;
        flag = 1'b0;
        e.v = 1'b0; e.d = 0; e.p = 1'b0;
        q.push_back(e);
        q.push_back(e);
        for (int k = 0; k < n + 2; k++) begin
            v = (k < n) && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: i = -2048;
                    1: i = 2047;
                    2: i = 0;
                    default: i = -1;
                endcase
            end else begin
                i = int'($urandom_range(0, 4095)) - 2048;
            end
            qq = ($urandom_range(0, 7) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            m = int'($urandom_range(0, 3));
            g = int'($urandom_range(0, 7));
            clr = ($urandom_range(0, 31) == 0);
            in_valid = v; in_i = 12'(i); in_q = 12'(qq); mode = 2'(m); gain_shift = 3'(g);
            clear_sat = clr;
            e.v = v;
            e.d = model(i, qq, m, g, clip);
            e.p = v && clip;
            q.push_back(e);
            tick();
            o = q.pop_front();
            if (o.v) last_d = o.d;
            if (o.p) flag = 1'b1;
            else if (clr) flag = 1'b0;
            n_checks++; if (out_valid !== o.v) $display("FAIL rnd_valid[%0d]: got %b want %b", k, out_valid, o.v); else n_pass++;
            n_checks++; if (out_data !== 12'(last_d)) $display("FAIL rnd_data[%0d]: got %0d want %0d", k, out_data, last_d); else n_pass++;
            n_checks++; if (sat_pulse !== o.p) $display("FAIL rnd_pulse[%0d]: got %b want %b", k, sat_pulse, o.p); else n_pass++;
            n_checks++; if (sat_flag !== flag) $display("FAIL rnd_flag[%0d]: got %b want %b", k, sat_flag, flag); else n_pass++;
        end
        in_valid = 1'b0;
        clear_sat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sideband();
        test_saturation();
        test_am_mute();
        test_back_to_back();
        test_bubbles();
        test_random(20000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
